// File: rtl/mem_port_arbiter3.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter3
//
// Three-requester round-robin arbiter for one shared memory port. A grant is
// taken from IDLE with one cycle of latency and then held, unchanged, until
// the owner's transaction completes (done) or the watchdog releases it.
// Every release passes through at least one IDLE cycle before the next grant.
//
// Parameters
//   TIMEOUT : watchdog limit in BUSY cycles (0 disables the watchdog)
//   CNT_W   : watchdog counter width, TIMEOUT < 2**CNT_W
//
// Ports
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   req     : per-requester request bits
//   done    : current owner's transaction finished this cycle
//   grant   : registered one-hot grant (000 when idle)
//   sel     : registered 3:1 datapath mux select (00/01/10, 11 never driven)
//   busy    : high while a grant is held
//   timeout : one-cycle pulse when the watchdog forcibly releases a grant
// ----------------------------------------------------------------------------
module mem_port_arbiter3 #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       done,
    output logic [2:0] grant,
    output logic [1:0] sel,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam bit              WD_EN   = (TIMEOUT > 0);
    // Last counter value of a grant's lifetime; the counter reads 0 in the
    // first BUSY cycle, so TIMEOUT-1 is reached in the TIMEOUT-th cycle.
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    state_t           state_q,   state_d;
    logic [2:0]       grant_q,   grant_d;
    logic [1:0]       sel_q,     sel_d;
    logic             busy_q,    busy_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [1:0]       last_q,    last_d;
    logic [1:0]       winner;

    // Successor in the 0 -> 1 -> 2 -> 0 ring.
    function automatic logic [1:0] ring_next(input logic [1:0] idx);
        case (idx)
            2'd0:    ring_next = 2'd1;
            2'd1:    ring_next = 2'd2;
            default: ring_next = 2'd0;
        endcase
    endfunction

    // Round-robin choice: last+1, then last+2, then last itself. Only
    // meaningful when at least one request bit is set.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] c1;
        logic [1:0] c2;
        c1 = ring_next(last);
        c2 = ring_next(c1);
        if (r[c1])
            rr_pick = c1;
        else if (r[c2])
            rr_pick = c2;
        else
            rr_pick = last;
    endfunction

    function automatic logic [2:0] one_hot(input logic [1:0] idx);
        case (idx)
            2'd0:    one_hot = 3'b001;
            2'd1:    one_hot = 3'b010;
            2'd2:    one_hot = 3'b100;
            default: one_hot = 3'b000;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;
        last_d    = last_q;
        winner    = rr_pick(req, last_q);

        case (state_q)
            ST_IDLE: begin
                // done is deliberately not looked at here.
                if (|req) begin
                    state_d = ST_BUSY;
                    sel_d   = winner;
                    grant_d = one_hot(winner);
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    last_d  = winner;
                end else begin
                    // sel keeps the previous owner so the mux stays put.
                    grant_d = 3'b000;
                    busy_d  = 1'b0;
                end
            end
            ST_BUSY: begin
                // done wins over a watchdog expiry in the same cycle.
                if (done) begin
                    state_d = ST_IDLE;
                    grant_d = 3'b000;
                    busy_d  = 1'b0;
                end else if (WD_EN && (cnt_q == WD_LAST)) begin
                    state_d   = ST_IDLE;
                    grant_d   = 3'b000;
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 3'b000;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Reset pointer of 2 gives requester 0 first priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= 3'b000;
            sel_q     <= 2'b00;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            last_q    <= 2'd2;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
        end
    end

    assign grant   = grant_q;
    assign sel     = sel_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule
